dlbf_coeffs_streamer: RTL and testbench
=======================================

Name: dlbf_coeffs_streamer

Overview:
Sequences read-out of the 64-bit beamforming coefficient BRAM (read port B) onto an AXI4-Stream master toward the AI Engine coefficient input. Software programs base address, block length and iteration count through CSR fields, then issues start. The block issues BRAM reads under a credit scheme so the stream tolerates arbitrary backpressure without losing words. TLAST marks the end of each coefficient block.

Parameters:
RD_LATENCY, 1, BRAM read latency in cycles from enb to valid doutb (legal 1..3).
FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LATENCY+1, power of 2.
ADDR_W, 16, BRAM word-address width.

Ports:
aclk  in  1  clock for all logic
aresetn  in  1  asynchronous active-low reset
cfg_base_addr  in  ADDR_W  first word address of block
cfg_num_words  in  16  words per block
cfg_num_iter  in  16  blocks to send; 0 = continuous until stop
ctrl_start  in  1  single-cycle start pulse
ctrl_stop  in  1  single-cycle stop request
enb  out  1  BRAM port B enable
addrb  out  ADDR_W  BRAM port B word address
doutb  in  64  BRAM port B read data
m_axis_tdata  out  64  coefficient word
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last word of block
sts_busy  out  1  high from accepted start until final beat accepted
sts_done  out  1  one-cycle pulse after final beat accepted
sts_iter_cnt  out  16  completed blocks in current run

Behaviour:
- Reset (async assert, sync release): state IDLE; enb=0, addrb=0, m_axis_tvalid=0, m_axis_tlast=0, tdata=0, sts_busy=0, sts_done=0, sts_iter_cnt=0, FIFO empty, credits=FIFO_DEPTH. Reset mid-run discards in-flight reads and FIFO contents; no beat emitted after reset.
- States: IDLE, ISSUE, DRAIN.
- IDLE: ctrl_start latches cfg_* into shadow regs, clears sts_iter_cnt, -> ISSUE, sts_busy=1 next cycle. If cfg_num_words=0: no reads, sts_done pulses the cycle after start, stay IDLE, busy stays 0. ctrl_stop in IDLE ignored.
- cfg_* changes after start have no effect until next start. ctrl_start while not IDLE ignored.
- ISSUE: each cycle enb=1 iff credits>0; credits = FIFO_DEPTH - (FIFO occupancy + reads in flight). Reads with enb=1 use addrb = base + word_idx, modulo 2^ADDR_W (wrap permitted). Read-valid tracked by RD_LATENCY-deep shift register of enb; tag (is_last_of_block) travels with it; data written into FIFO on arrival.
- word_idx increments per issued read; at num_words-1 it wraps to 0 and block_issue_cnt increments. When block_issue_cnt reaches num_iter (num_iter!=0), or a stop is pending at block boundary, -> DRAIN.
- ctrl_stop in ISSUE/DRAIN sets stop_pending; the current block always completes (no partial block ever emitted); no further blocks issued.
- DRAIN: enb=0; wait for FIFO empty and zero in flight with final beat accepted; then sts_done=1 for one cycle, sts_busy=0, -> IDLE.
- Stream: tvalid = FIFO non-empty; tdata/tlast from FIFO head; once tvalid high, tdata/tlast/tvalid held stable until tready. Beat transfers on tvalid&&tready. Simultaneous FIFO push and pop legal at full occupancy only via credit accounting (never overflow).
- sts_iter_cnt increments on each accepted beat with tlast=1; saturates at 16'hFFFF in continuous mode.
- Throughput: with tready held 1, one beat per cycle sustained after first beat; first beat appears RD_LATENCY+1 cycles after start cycle.

Test Plan:
- base=0x0010, num_words=4, num_iter=2, tready=1 -> 8 beats addresses 0x10..0x13 twice, tlast on beats 4 and 8, sts_iter_cnt=2, sts_done single pulse, busy low after.
- Random tready (50%) with num_words=37, num_iter=3, RD_LATENCY=2 -> 111 beats, data order exact, no drop/duplication, tdata stable while stalled, FIFO never overflows.
- base=0xFFFE, num_words=4 -> addrb sequence FFFE, FFFF, 0000, 0001.
- num_iter=0, stop asserted mid-block 3 -> block 3 completes with tlast, no block 4, done pulse, sts_iter_cnt=3.
- num_words=0 start -> no enb, done pulse next cycle, busy never high; start while busy -> ignored, output unchanged.
- aresetn asserted mid-block with tready=0 -> tvalid drops immediately, all status 0; a new start after release yields a clean block from base.

Source files
------------

// File: rtl/dlbf_coeffs_streamer_if.sv
// AXI4-Stream link carrying 64-bit beamforming coefficients toward the AI Engine.
interface dlbf_coeffs_streamer_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dlbf_coeffs_streamer.sv
// Streams coefficient blocks from BRAM port B onto AXI4-Stream; reads are credit-gated
// so an output skid FIFO absorbs every in-flight word under arbitrary backpressure.
module dlbf_coeffs_streamer #(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [ADDR_W-1:0]      cfg_base_addr,
    input  logic [15:0]            cfg_num_words,
    input  logic [15:0]            cfg_num_iter,
    input  logic                   ctrl_start,
    input  logic                   ctrl_stop,
    output logic                   enb,
    output logic [ADDR_W-1:0]      addrb,
    input  logic [63:0]            doutb,
    dlbf_coeffs_streamer_if.master m_axis,
    output logic                   sts_busy,
    output logic                   sts_done,
    output logic [15:0]            sts_iter_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [15:0]       num_words_q, num_iter_q;
    logic [15:0]       word_idx_q, blk_cnt_q, iter_cnt_q;
    logic              stop_pend_q, done_q, done_d, start_acc;
    logic [CNT_W-1:0]  credit_q, fifo_cnt_q, credit_rel;
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [63:0]       fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [RD_LATENCY-1:0] rd_vld_p, rd_last_p;
    logic              arr_vld, arr_last, fifo_empty, fire, push, pop;
    logic              last_word, final_blk;

    assign arr_vld    = rd_vld_p[RD_LATENCY-1];
    assign arr_last   = rd_last_p[RD_LATENCY-1];
    assign fifo_empty = (fifo_cnt_q == '0);

    // Empty FIFO passes arriving read data straight through; a stalled word lands in the FIFO head.
    assign m_axis.tvalid = !fifo_empty || arr_vld;
    assign m_axis.tdata  = fifo_empty ? (arr_vld ? doutb : 64'd0) : fifo_data[rptr_q];
    assign m_axis.tlast  = fifo_empty ? (arr_vld && arr_last) : fifo_last[rptr_q];
    assign fire = m_axis.tvalid && m_axis.tready;
    assign push = arr_vld && !(fifo_empty && m_axis.tready);
    assign pop  = !fifo_empty && m_axis.tready;

    assign credit_rel = credit_q + CNT_W'(fire);
    assign last_word  = (word_idx_q == num_words_q - 16'd1);
    assign final_blk  = ((num_iter_q != 16'd0) && (blk_cnt_q + 16'd1 == num_iter_q))
                        || stop_pend_q || ctrl_stop;
    assign addrb      = enb ? (base_q + ADDR_W'(word_idx_q)) : '0;
    assign sts_busy   = (state_q != IDLE);
    assign sts_done   = done_q;
    assign sts_iter_cnt = iter_cnt_q;

    always_comb begin
        state_d   = state_q;
        enb       = 1'b0;
        done_d    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    start_acc = 1'b1;
                    if (cfg_num_words == 16'd0) done_d  = 1'b1;
                    else                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                enb = (credit_q != '0);
                if (enb && last_word && final_blk) state_d = DRAIN;
            end
            DRAIN: begin
                // All credits home after this cycle means the final beat is being accepted now.
                if (credit_rel == CNT_W'(FIFO_DEPTH)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            credit_q    <= CNT_W'(FIFO_DEPTH);
            fifo_cnt_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_vld_p    <= '0;
            rd_last_p   <= '0;
            word_idx_q  <= '0;
            blk_cnt_q   <= '0;
            iter_cnt_q  <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            credit_q   <= credit_rel - CNT_W'(enb);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            // Read-return pipeline: valid and end-of-block tag track the BRAM latency.
            rd_vld_p[0]  <= enb;
            rd_last_p[0] <= enb && last_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_p[i]  <= rd_vld_p[i-1];
                rd_last_p[i] <= rd_last_p[i-1];
            end
            if (start_acc) begin
                word_idx_q  <= '0;
                blk_cnt_q   <= '0;
                iter_cnt_q  <= '0;
                stop_pend_q <= 1'b0;
            end else begin
                if (enb) begin
                    word_idx_q <= last_word ? 16'd0 : word_idx_q + 16'd1;
                    if (last_word) blk_cnt_q <= blk_cnt_q + 16'd1;
                end
                if (ctrl_stop && (state_q != IDLE)) stop_pend_q <= 1'b1;
                if (fire && m_axis.tlast && (iter_cnt_q != 16'hFFFF))
                    iter_cnt_q <= iter_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (start_acc) begin
            base_q      <= cfg_base_addr;
            num_words_q <= cfg_num_words;
            num_iter_q  <= cfg_num_iter;
        end
        if (push) begin
            fifo_data[wptr_q] <= doutb;
            fifo_last[wptr_q] <= arr_last;
        end
    end
endmodule

// File: tb/tb_dlbf_coeffs_streamer.sv
// Randomized bench for dlbf_coeffs_streamer against a queue-based model of the emitted beat stream.
module tb_dlbf_coeffs_streamer;
    localparam int RDL = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] cfg_base_addr = '0, cfg_num_words = '0, cfg_num_iter = '0;
    logic        ctrl_start = 1'b0, ctrl_stop = 1'b0;
    logic        enb;
    logic [15:0] addrb;
    logic [63:0] doutb;
    logic        sts_busy, sts_done;
    logic [15:0] sts_iter_cnt;
    logic [63:0] bram_pipe [RDL];

    dlbf_coeffs_streamer_if axis ();

    dlbf_coeffs_streamer #(.RD_LATENCY(RDL), .FIFO_DEPTH(4), .ADDR_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words), .cfg_num_iter(cfg_num_iter),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
        .enb(enb), .addrb(addrb), .doutb(doutb),
        .m_axis(axis),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_iter_cnt(sts_iter_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [63:0] coef(input logic [15:0] a);
        return {a ^ 16'hA5A5, 16'hC0EF, ~a, a};
    endfunction

    // BRAM model: registered read with RDL cycles of latency.
    always @(posedge aclk) begin
        if (enb) bram_pipe[0] <= coef(addrb);
        for (int i = 1; i < RDL; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign doutb = bram_pipe[RDL-1];

    typedef struct { logic [63:0] data; logic last; } beat_t;
    beat_t       exp_q [$];
    logic [15:0] addr_log [$];
    int n_vec = 0, n_err = 0;
    int beats = 0, done_cnt = 0;
    int tready_mode = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        axis.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            axis.tready = (tready_mode == 2) ? 1'($urandom_range(0, 1)) : (tready_mode == 1);
        end
    end

    // Output monitor: every accepted beat is compared to the model queue; stalled beats must hold.
    initial begin
        bit          stalled = 0, have;
        logic [63:0] st_data;
        logic        st_last;
        beat_t       b;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stalled = 0;
            end else begin
                if (sts_done) done_cnt++;
                if (enb) addr_log.push_back(addrb);
                if (stalled) begin
                    chk("hold_tvalid", 64'(axis.tvalid), 64'd1);
                    chk("hold_tdata", axis.tdata, st_data);
                    chk("hold_tlast", 64'(axis.tlast), 64'(st_last));
                end
                if (axis.tvalid && axis.tready) begin
                    beats++;
                    have = (exp_q.size() != 0);
                    chk("beat_expected", 64'(have), 64'd1);
                    if (have) begin
                        b = exp_q.pop_front();
                        chk("tdata", axis.tdata, b.data);
                        chk("tlast", 64'(axis.tlast), 64'(b.last));
                    end
                end
                stalled = axis.tvalid && !axis.tready;
                st_data = axis.tdata;
                st_last = axis.tlast;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] base, input logic [15:0] nw,
                             input logic [15:0] ni, input int nblk);
        beat_t b;
        for (int k = 0; k < nblk; k++)
            for (int w = 0; w < int'(nw); w++) begin
                b.data = coef(base + 16'(w));
                b.last = (w == int'(nw) - 1);
                exp_q.push_back(b);
            end
        cfg_base_addr = base;
        cfg_num_words = nw;
        cfg_num_iter  = ni;
        ctrl_start    = 1'b1;
        tick();
        ctrl_start    = 1'b0;
        cfg_base_addr = 16'($urandom);
        cfg_num_words = 16'($urandom);
        cfg_num_iter  = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, input logic [15:0] exp_iter);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        chk("busy_at_done", 64'(sts_busy), 64'd0);
        chk("iter_cnt", 64'(sts_iter_cnt), 64'(exp_iter));
        repeat (2) @(negedge aclk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("leftover_beats", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        int lat, b0;
        logic [15:0] wrap_exp [4];

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        chk("rst_enb", 64'(enb), 64'd0);
        chk("rst_addrb", 64'(addrb), 64'd0);
        chk("rst_busy", 64'(sts_busy), 64'd0);
        chk("rst_iter", 64'(sts_iter_cnt), 64'd0);
        aresetn = 1'b1;
        tick();

        // Basic run: latency, sustained throughput, tlast placement.
        tready_mode = 1;
        tick();
        b0 = beats;
        start_run(16'h0010, 16'd4, 16'd2, 2);
        chk("busy_after_start", 64'(sts_busy), 64'd1);
        lat = 0;
        while (!axis.tvalid && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        chk("first_beat_latency", 64'(lat), 64'(RDL + 1));
        repeat (7) @(negedge aclk);
        chk("throughput_beats", 64'(beats - b0), 64'd8);
        wait_done(100, 16'd2);

        // Random backpressure over a long multi-block run.
        tready_mode = 2;
        start_run(16'($urandom), 16'd37, 16'd3, 3);
        wait_done(3000, 16'd3);

        // Address wrap at the top of the BRAM space.
        tready_mode = 1;
        addr_log.delete();
        start_run(16'hFFFE, 16'd4, 16'd1, 1);
        wait_done(100, 16'd1);
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        chk("wrap_addr_count", 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("wrap_addrb", 64'(addr_log[i]), 64'(wrap_exp[i]));

        // Continuous mode stopped in the middle of the third block.
        b0 = beats;
        start_run(16'h0300, 16'd16, 16'd0, 3);
        lat = 0;
        while (beats - b0 < 37 && lat < 200) begin
            @(negedge aclk);
            lat++;
        end
        tick();
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        wait_done(300, 16'd3);

        // Zero-length block: immediate done, no reads, never busy.
        addr_log.delete();
        start_run(16'h0050, 16'd0, 16'd3, 0);
        chk("zero_done", 64'(sts_done), 64'd1);
        chk("zero_busy", 64'(sts_busy), 64'd0);
        tick();
        chk("zero_done_low", 64'(sts_done), 64'd0);
        chk("zero_no_reads", 64'(addr_log.size()), 64'd0);

        // Start while busy must be ignored.
        start_run(16'h0100, 16'd4, 16'd1, 1);
        tick();
        start_run(16'h0200, 16'd2, 16'd5, 0);
        wait_done(100, 16'd1);

        // Asynchronous reset mid-block while stalled, then a clean restart.
        tready_mode = 0;
        tick();
        start_run(16'h0040, 16'd8, 16'd1, 1);
        repeat (6) tick();
        chk("pre_rst_tvalid", 64'(axis.tvalid), 64'd1);
        #1;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("mid_rst_busy", 64'(sts_busy), 64'd0);
        chk("mid_rst_done", 64'(sts_done), 64'd0);
        chk("mid_rst_iter", 64'(sts_iter_cnt), 64'd0);
        chk("mid_rst_enb", 64'(enb), 64'd0);
        repeat (2) @(negedge aclk);
        #2;
        aresetn = 1'b1;
        tick();
        tready_mode = 1;
        tick();
        start_run(16'h0040, 16'd8, 16'd1, 1);
        wait_done(100, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
